bcd_xs3_seq_ctrl: RTL

Sequencer that converts a packed multi-digit BCD word to excess-3 by time-sharing one external single-digit bcd_excess3 converter.
- Accepts a word over a valid/ready handshake.
- Feeds one nibble per cycle to the converter, least-significant digit first.
- Collects the converted nibbles and presents the packed result over a valid/ready handshake.
- Sits between a number-formatting front end and a display/encoder stage.

---
 rtl/bcd_xs3_seq_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bcd_xs3_seq_ctrl.sv
// Time-shares one external single-digit BCD->excess-3 converter across a packed multi-digit word.
// Optional macro BCD_XS3_ERR_CHECK_EN flags digits above 9 in err_mask and forces their result nibble to 4'hF.
module bcd_xs3_seq_ctrl #(
  parameter  int DIGITS = 4,
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_word,
  input  logic                abort,
  output logic [3:0]          conv_bcd,
  input  logic [3:0]          conv_xs3,
  output logic                busy,
  output logic [IDXW-1:0]     digit_idx,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] xs3_word,
  output logic [DIGITS-1:0]   err_mask
);

  localparam int W = 4 * DIGITS;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t         state;
  logic [W-1:0]   shift_reg;
  logic [3:0]     cap_nibble;
  logic           cap_err;

  // The digit under conversion always comes straight from the shift register,
  // so there is no combinational path from bcd_word to the converter.
  assign conv_bcd = shift_reg[3:0];

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    cap_nibble = conv_xs3;
    cap_err    = 1'b0;
`ifdef BCD_XS3_ERR_CHECK_EN
    if (conv_bcd > 4'd9) begin
      cap_nibble = 4'hF;
      cap_err    = 1'b1;
    end
`endif
  end

`ifdef BCD_XS3_ERR_CHECK_EN
  logic [DIGITS-1:0] err_q;
  assign err_mask = err_q;
`else
  assign err_mask = '0;
`endif

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      xs3_word  <= '0;
      digit_idx <= '0;
      shift_reg <= '0;
`ifdef BCD_XS3_ERR_CHECK_EN
      err_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready gates acceptance so the first cycle after reset never accepts.
          if (in_ready && in_valid && !abort) begin
            shift_reg <= bcd_word;
            digit_idx <= '0;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            state     <= CONV;
`ifdef BCD_XS3_ERR_CHECK_EN
            err_q     <= '0;
`endif
          end else begin
            in_ready  <= 1'b1;
          end
        end

        CONV: begin
          if (abort) begin
            shift_reg <= '0;
            digit_idx <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            xs3_word[4*digit_idx +: 4] <= cap_nibble;
`ifdef BCD_XS3_ERR_CHECK_EN
            if (cap_err) err_q[digit_idx] <= 1'b1;
`endif
            shift_reg <= shift_reg >> 4;
            if (digit_idx == LAST_IDX) begin
              digit_idx <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              digit_idx <= digit_idx + 1'b1;
            end
          end
        end

        DONE: begin
          if (abort || out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

`ifndef BCD_XS3_ERR_CHECK_EN
  // Capture error flag is only consumed when error checking is built in.
  logic unused_cap_err;
  assign unused_cap_err = cap_err;
`endif

endmodule
